// File: rtl/vc_demux_ctrl_pkg.sv
// Shared constants for the VC demux controller: state encoding {inflight, hold_valid}
// and VC index values.
package vc_demux_ctrl_pkg;

    typedef logic [1:0] demux_st_t;

    localparam demux_st_t ST_IDLE      = 2'b00;
    localparam demux_st_t ST_HOLD      = 2'b01;
    localparam demux_st_t ST_FLOW      = 2'b10;
    localparam demux_st_t ST_HOLD_INFL = 2'b11;

    localparam logic VC0 = 1'b0;
    localparam logic VC1 = 1'b1;

    function automatic logic vc_is_full(input logic tgt, input logic full0, input logic full1);
        return (tgt == VC1) ? full1 : full0;
    endfunction

endpackage

// File: rtl/vc_hold_reg.sv
// One-entry holding register for a word whose target VC was full on arrival.
// Load takes priority over unload; the two never coincide in the demux controller.
module vc_hold_reg #(
    parameter int unsigned DATA_SIZE = 6
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 load,
    input  logic                 unload,
    input  logic [DATA_SIZE-1:0] din,
    output logic                 valid,
    output logic [DATA_SIZE-1:0] dout
);

    logic                 valid_q, valid_d;
    logic [DATA_SIZE-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/vc_demux_ctrl.sv
// Drains the main FIFO and routes each word to VC0 or VC1 by its selector bit,
// parking a word in the hold register when its target fills while it is in flight.
module vc_demux_ctrl
    import vc_demux_ctrl_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 6,
    parameter int unsigned VC_SEL_BIT = 5
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 fifo_empty_main,
    input  logic                 fifo_pause_main,
    input  logic [DATA_SIZE-1:0] data_demux_vc,
    input  logic                 vc0_full,
    input  logic                 vc1_full,
    input  logic                 vc0_pause,
    input  logic                 vc1_pause,
    output logic                 pop_main,
    output logic                 push_vc0,
    output logic                 push_vc1,
    output logic [DATA_SIZE-1:0] data_vc,
    output logic                 hold_valid,
    output logic                 demux_error
);

    logic                 inflight_q;
    logic                 demux_error_q, demux_error_d;
    logic                 hold_load, hold_unload;
    logic [DATA_SIZE-1:0] hold_data;
    demux_st_t            st;
    logic                 arr_tgt, hold_tgt;

    // Main-FIFO almost-full is status only; popping ignores it.
    logic unused_pause_main;
    assign unused_pause_main = fifo_pause_main;

    // Pop only when every downstream resource has room for the returning word.
    assign pop_main = reset_L & ~fifo_empty_main & ~hold_valid &
                      ~vc0_full & ~vc1_full & ~vc0_pause & ~vc1_pause;

    assign st       = {inflight_q, hold_valid};
    assign arr_tgt  = data_demux_vc[VC_SEL_BIT];
    assign hold_tgt = hold_data[VC_SEL_BIT];

    always_comb begin
        push_vc0      = 1'b0;
        push_vc1      = 1'b0;
        data_vc       = '0;
        hold_load     = 1'b0;
        hold_unload   = 1'b0;
        demux_error_d = demux_error_q;
        unique case (st)
            ST_FLOW: begin
                if (!vc_is_full(arr_tgt, vc0_full, vc1_full)) begin
                    data_vc  = data_demux_vc;
                    push_vc0 = (arr_tgt == VC0);
                    push_vc1 = (arr_tgt == VC1);
                end else begin
                    hold_load = 1'b1;
                end
            end
            ST_HOLD, ST_HOLD_INFL: begin
                // The held word always wins; a word arriving on top of it is dropped.
                data_vc = hold_data;
                if (!vc_is_full(hold_tgt, vc0_full, vc1_full)) begin
                    push_vc0    = (hold_tgt == VC0);
                    push_vc1    = (hold_tgt == VC1);
                    hold_unload = 1'b1;
                end
                if (st == ST_HOLD_INFL) begin
                    demux_error_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            inflight_q    <= 1'b0;
            demux_error_q <= 1'b0;
        end else begin
            inflight_q    <= pop_main;
            demux_error_q <= demux_error_d;
        end
    end

    vc_hold_reg #(
        .DATA_SIZE(DATA_SIZE)
    ) u_hold (
        .clk    (clk),
        .reset_L(reset_L),
        .load   (hold_load),
        .unload (hold_unload),
        .din    (data_demux_vc),
        .valid  (hold_valid),
        .dout   (hold_data)
    );

    assign demux_error = demux_error_q;

endmodule
